pwm_ramp_ctrl: RTL and testbench
================================

# pwm_ramp_ctrl

Sequencer for the PWM generator's duty-step interface. It accepts a target duty over a valid/ready handshake and walks the PWM duty one step at a time toward it. Each step is a fixed-width `duty_inc` or `duty_dec` pulse, and consecutive steps are separated by a programmable hold interval. The block sits between the slow-control register logic and the PWM instance, drives that instance's `duty_inc`/`duty_dec` pins exclusively, and keeps a shadow copy of the current duty.

## Interface
- `DUTY_W`, 3: duty width; matches the PWM `duty` input.
- `HOLD_W`, 8: width of the hold-interval request field.
- `PULSE_CYC`, 2: cycles each inc/dec pulse is held high (≥1).
- `DUTY_INIT`, 4: shadow duty after reset; equals the preset driven on the PWM `duty` input.

- `clk` in 1: system clock, shared with the PWM instance.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: target request valid.
- `req_ready` out 1: high only in IDLE.
- `req_duty` in DUTY_W: target duty, sampled at accept.
- `req_hold` in HOLD_W: gap cycles between steps, sampled at accept.
- `duty_inc` out 1: increment pulse to the PWM.
- `duty_dec` out 1: decrement pulse to the PWM.
- `cur_duty` out DUTY_W: shadow of the PWM duty.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle completion strobe.
- `abort` in 1: present only with `PWM_RAMP_ABORT_EN`.
- `aborted` out 1: qualifies `done`; present only with `PWM_RAMP_ABORT_EN`.

## Operation
- States: IDLE, PULSE, HOLD, DONE.
- IDLE: `req_ready`=1. Accept = `req_valid`&&`req_ready` at a rising edge. At accept, latch target T and gap G = max(`req_hold`,1).
  - T == `cur_duty` → DONE.
  - Otherwise → PULSE, with direction up if T > `cur_duty`, else down.
- PULSE: drive `duty_inc` (up) or `duty_dec` (down) high for exactly PULSE_CYC cycles. At the edge ending the last pulse cycle, `cur_duty` ±1. Then:
  - new `cur_duty` == T → DONE;
  - otherwise → HOLD.
- HOLD: both pulses low for G cycles, then → PULSE. A minimum one-cycle low gap guarantees the PWM sees a distinct edge per step.
- DONE: `done`=1 for one cycle → IDLE.
- `duty_inc` and `duty_dec` are never high together. Both are low outside PULSE.
- Arithmetic is unsigned DUTY_W. Because T is DUTY_W wide and stepping always moves toward T, `cur_duty` cannot wrap.
- `req_valid` while busy is not accepted. The requester holds it, and acceptance occurs in the first IDLE cycle after DONE.
- Reset (any state, mid-pulse included) forces IDLE immediately. The PWM is reset by the same `rst_n` tree so the shadow stays coherent.
- Reset values: `req_ready`=1, `duty_inc`=0, `duty_dec`=0, `cur_duty`=DUTY_INIT, `busy`=0, `done`=0, `aborted`=0.

## Timing
- All outputs are registered, except `req_ready`, `busy` and `done`, which decode directly from the state register.
- Accept at edge 0 → first pulse high in cycles 1..PULSE_CYC.
- An N-step ramp occupies N·PULSE_CYC + (N−1)·G cycles. `done` is high in the following cycle. A new accept is possible in the cycle after `done`.
- T == `cur_duty`: `done` in cycle 1, no pulses.

## Configuration
- `PWM_RAMP_ABORT_EN` defined: adds `abort` and `aborted`.
  - `abort` sampled high in HOLD → DONE next cycle.
  - `abort` in PULSE → the current pulse completes its full PULSE_CYC and `cur_duty` updates, then → DONE.
  - `abort` in IDLE or DONE is ignored.
  - `aborted`=1 alongside `done` only for an aborted ramp.
- `PWM_RAMP_ABORT_EN` undefined: ports absent, and every ramp runs to T.

## Test plan
- Reset: hold `rst_n`=0 → `cur_duty`=4, `req_ready`=1, all other outputs 0. Assert `rst_n` low mid-pulse → `duty_inc` drops asynchronously and `cur_duty` returns to 4.
- Ramp up, T=7, `req_hold`=3, PULSE_CYC=2, accept at edge 0 → `duty_inc` high in cycles 1–2, 6–7 and 11–12; `done` in cycle 13; `cur_duty`=7.
- Ramp down, T=0 from 7, `req_hold`=0 → seven 2-cycle `duty_dec` pulses separated by 1-cycle gaps; `done` in cycle 21; `duty_inc` never high.
- Null request, T=4 with `cur_duty`=4 → no pulses; `done` in cycle 1.
- Back-pressure: `req_valid` held during a ramp → `req_ready`=0 until the cycle after `done`, then the second request is accepted and executed.
- With `PWM_RAMP_ABORT_EN`: ramp 0→7 with `req_hold`=5, assert `abort` in HOLD after the 2nd step → `done`=1 and `aborted`=1 next cycle, `cur_duty`=2, no further pulses.

Source files
------------

// File: rtl/pwm_ramp_ctrl_if.sv
// Request/step bundle between the slow-control requester and pwm_ramp_ctrl.
// PWM_RAMP_ABORT_EN adds the abort/aborted pair.
interface pwm_ramp_ctrl_if #(
    parameter int DUTY_W = 3,
    parameter int HOLD_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [DUTY_W-1:0] req_duty;
    logic [HOLD_W-1:0] req_hold;
    logic              duty_inc;
    logic              duty_dec;
    logic [DUTY_W-1:0] cur_duty;
    logic              busy;
    logic              done;
`ifdef PWM_RAMP_ABORT_EN
    logic              abort;
    logic              aborted;

    modport master (
        output req_valid, req_duty, req_hold, abort,
        input  req_ready, duty_inc, duty_dec, cur_duty, busy, done, aborted
    );
    modport slave (
        input  req_valid, req_duty, req_hold, abort,
        output req_ready, duty_inc, duty_dec, cur_duty, busy, done, aborted
    );
`else
    modport master (
        output req_valid, req_duty, req_hold,
        input  req_ready, duty_inc, duty_dec, cur_duty, busy, done
    );
    modport slave (
        input  req_valid, req_duty, req_hold,
        output req_ready, duty_inc, duty_dec, cur_duty, busy, done
    );
`endif
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Walks the PWM duty one inc/dec pulse at a time toward a requested target.
// Optional abort support is enabled by defining PWM_RAMP_ABORT_EN.
module pwm_ramp_ctrl #(
    parameter int DUTY_W    = 3,
    parameter int HOLD_W    = 8,
    parameter int PULSE_CYC = 2,
    parameter int DUTY_INIT = 4
) (
    input logic            clk,
    input logic            rst_n,
    pwm_ramp_ctrl_if.slave bus
);
    localparam int PCW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] cur_q;
    logic [DUTY_W-1:0] step_duty;
    logic [HOLD_W-1:0] gap;
    logic [HOLD_W-1:0] hcnt;
    logic [PCW-1:0]    pcnt;
    logic              dir_up;
    logic              inc_q;
    logic              dec_q;
    logic              stop_req;
`ifdef PWM_RAMP_ABORT_EN
    logic              abort_pend;
    logic              aborted_q;
`endif

    always_comb begin
        step_duty = dir_up ? cur_q + 1'b1 : cur_q - 1'b1;
`ifdef PWM_RAMP_ABORT_EN
        stop_req  = abort_pend | bus.abort;
`else
        stop_req  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            target     <= '0;
            cur_q      <= DUTY_W'(DUTY_INIT);
            gap        <= HOLD_W'(1);
            hcnt       <= '0;
            pcnt       <= '0;
            dir_up     <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
`ifdef PWM_RAMP_ABORT_EN
            abort_pend <= 1'b0;
            aborted_q  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        target <= bus.req_duty;
                        gap    <= (bus.req_hold == '0) ? HOLD_W'(1) : bus.req_hold;
                        pcnt   <= '0;
                        if (bus.req_duty == cur_q) begin
                            state <= ST_DONE;
                        end else begin
                            state  <= ST_PULSE;
                            dir_up <= bus.req_duty > cur_q;
                            inc_q  <= bus.req_duty > cur_q;
                            dec_q  <= bus.req_duty < cur_q;
                        end
                    end
                end
                ST_PULSE: begin
`ifdef PWM_RAMP_ABORT_EN
                    abort_pend <= stop_req;
`endif
                    // The shadow duty moves on the same edge the pulse falls.
                    if (pcnt == PCW'(PULSE_CYC - 1)) begin
                        inc_q <= 1'b0;
                        dec_q <= 1'b0;
                        cur_q <= step_duty;
                        hcnt  <= '0;
                        if (step_duty == target || stop_req) begin
                            state <= ST_DONE;
`ifdef PWM_RAMP_ABORT_EN
                            aborted_q <= stop_req;
`endif
                        end else begin
                            state <= ST_HOLD;
                        end
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (stop_req) begin
                        state <= ST_DONE;
`ifdef PWM_RAMP_ABORT_EN
                        aborted_q <= 1'b1;
`endif
                    end else if (hcnt == gap - 1'b1) begin
                        state <= ST_PULSE;
                        pcnt  <= '0;
                        inc_q <= dir_up;
                        dec_q <= ~dir_up;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
`ifdef PWM_RAMP_ABORT_EN
                    abort_pend <= 1'b0;
                    aborted_q  <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.duty_inc  = inc_q;
    assign bus.duty_dec  = dec_q;
    assign bus.cur_duty  = cur_q;
`ifdef PWM_RAMP_ABORT_EN
    assign bus.aborted   = aborted_q;
`endif
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed, table-driven bench for pwm_ramp_ctrl (DUTY_INIT=4, PULSE_CYC=2).
// Abort sequence is compiled in only when PWM_RAMP_ABORT_EN is defined.
module tb_pwm_ramp_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pwm_ramp_ctrl_if #(.DUTY_W(3), .HOLD_W(8)) bif ();

    pwm_ramp_ctrl #(
        .DUTY_W(3), .HOLD_W(8), .PULSE_CYC(2), .DUTY_INIT(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bif)
    );

    typedef struct {
        logic [2:0]  duty;
        logic [7:0]  hold;
        int          exp_done;
        logic [2:0]  exp_cur;
        logic [31:0] exp_inc;
        logic [31:0] exp_dec;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Issue one request from an IDLE cycle, record the pulse pattern by cycle
    // number (cycle 1 follows the accepting edge), and return in the next IDLE cycle.
    task automatic run_req(input logic [2:0] d, input logic [7:0] h, output int done_cyc,
                           output logic [31:0] inc_m, output logic [31:0] dec_m,
                           output logic both);
        done_cyc = -1;
        inc_m = '0;
        dec_m = '0;
        both = 1'b0;
        bif.req_duty = d;
        bif.req_hold = h;
        bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        for (int c = 1; c < 64; c++) begin
            if (c < 32) begin
                inc_m[c] = bif.duty_inc;
                dec_m[c] = bif.duty_dec;
            end
            if (bif.duty_inc && bif.duty_dec) both = 1'b1;
            if (bif.done) begin
                done_cyc = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int          dc;
        logic [31:0] im;
        logic [31:0] dm;
        logic        bo;
        logic        ready_leak;

        vecs[0] = '{duty: 3'd4, hold: 8'd9, exp_done: 1,  exp_cur: 3'd4, exp_inc: 32'h0,    exp_dec: 32'h0};
        vecs[1] = '{duty: 3'd7, hold: 8'd3, exp_done: 13, exp_cur: 3'd7, exp_inc: 32'h18C6, exp_dec: 32'h0};
        vecs[2] = '{duty: 3'd0, hold: 8'd0, exp_done: 21, exp_cur: 3'd0, exp_inc: 32'h0,    exp_dec: 32'h1B6DB6};
        vecs[3] = '{duty: 3'd2, hold: 8'd1, exp_done: 6,  exp_cur: 3'd2, exp_inc: 32'h36,   exp_dec: 32'h0};
        vecs[4] = '{duty: 3'd1, hold: 8'd2, exp_done: 3,  exp_cur: 3'd1, exp_inc: 32'h0,    exp_dec: 32'h6};

        bif.req_valid = 1'b0;
        bif.req_duty  = '0;
        bif.req_hold  = '0;
`ifdef PWM_RAMP_ABORT_EN
        bif.abort     = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cur_duty", 32'(bif.cur_duty), 32'd4);
        check("rst_req_ready", 32'(bif.req_ready), 32'd1);
        check("rst_inc_dec", {30'd0, bif.duty_inc, bif.duty_dec}, 32'd0);
        check("rst_busy_done", {30'd0, bif.busy, bif.done}, 32'd0);
`ifdef PWM_RAMP_ABORT_EN
        check("rst_aborted", 32'(bif.aborted), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_req(vecs[i].duty, vecs[i].hold, dc, im, dm, bo);
            check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_cur_duty", i), 32'(bif.cur_duty), 32'(vecs[i].exp_cur));
            check($sformatf("v%0d_inc_mask", i), im, vecs[i].exp_inc);
            check($sformatf("v%0d_dec_mask", i), dm, vecs[i].exp_dec);
            check($sformatf("v%0d_inc_dec_overlap", i), 32'(bo), 32'd0);
        end

        // Back-pressure: request held through a 1->3 ramp, retargeted to 5 while busy
        bif.req_duty = 3'd3;
        bif.req_hold = 8'd0;
        bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_duty = 3'd5;
        ready_leak = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            if (bif.req_ready) ready_leak = 1'b1;
            @(posedge clk); #1;
        end
        check("bp_ready_low_busy", 32'(ready_leak), 32'd0);
        check("bp_done_c6", {30'd0, bif.done, bif.req_ready}, 32'd2);
        check("bp_cur_first", 32'(bif.cur_duty), 32'd3);
        @(posedge clk); #1;
        check("bp_ready_c7", {30'd0, bif.req_ready, bif.done}, 32'd2);
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        check("bp_second_accept", {29'd0, bif.duty_inc, bif.duty_dec, bif.busy}, 32'd5);
        dc = -1;
        for (int c = 1; c < 40; c++) begin
            if (bif.done) begin
                dc = c;
                break;
            end
            @(posedge clk); #1;
        end
        check("bp_second_done", 32'(dc), 32'd6);
        check("bp_second_cur", 32'(bif.cur_duty), 32'd5);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a pulse
        bif.req_duty = 3'd7;
        bif.req_hold = 8'd0;
        bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        check("mid_inc_high", 32'(bif.duty_inc), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_inc", 32'(bif.duty_inc), 32'd0);
        check("mid_rst_cur", 32'(bif.cur_duty), 32'd4);
        check("mid_rst_ready", {30'd0, bif.req_ready, bif.busy}, 32'd2);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef PWM_RAMP_ABORT_EN
        run_req(3'd0, 8'd0, dc, im, dm, bo);
        check("ab_pre_done", 32'(dc), 32'd12);
        check("ab_pre_cur", 32'(bif.cur_duty), 32'd0);
        bif.req_duty = 3'd7;
        bif.req_hold = 8'd5;
        bif.req_valid = 1'b1;
        @(posedge clk); #1;
        bif.req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("ab_hold_cycle10", {29'd0, bif.busy, bif.duty_inc, bif.done}, 32'd4);
        bif.abort = 1'b1;
        @(posedge clk); #1;
        bif.abort = 1'b0;
        check("ab_done_aborted", {30'd0, bif.done, bif.aborted}, 32'd3);
        check("ab_cur", 32'(bif.cur_duty), 32'd2);
        bo = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bif.duty_inc || bif.duty_dec) bo = 1'b1;
        end
        check("ab_no_more_pulses", 32'(bo), 32'd0);
        check("ab_idle_cur", {27'd0, bif.busy, bif.aborted, bif.cur_duty}, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
